// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: sequential, branch, jump, call/return via a
// return-address stack, trap entry/return, with target-alignment trapping.
module pc_sequencer #(
    parameter int                    WORD_SIZE    = 32,
    parameter logic [WORD_SIZE-1:0]  RESET_VECTOR = '0,
    parameter logic [WORD_SIZE-1:0]  TRAP_VECTOR  = 'h100,
    parameter int                    INST_BYTES   = 4,
    parameter int                    RAS_DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [2:0]                   op,
    input  logic [WORD_SIZE-1:0]         X,
    input  logic                         clr_err,
    output logic [WORD_SIZE-1:0]         addr,
    output logic [WORD_SIZE-1:0]         next_addr,
    output logic [WORD_SIZE-1:0]         epc,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         misaligned,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [WORD_SIZE-1:0] INC        = WORD_SIZE'(INST_BYTES);
    localparam logic [WORD_SIZE-1:0] ALIGN_MASK = WORD_SIZE'(INST_BYTES - 1);
    localparam logic [CW-1:0]        FULL_CNT   = CW'(RAS_DEPTH);

    typedef enum logic [2:0] {
        OP_SEQ    = 3'd0,
        OP_BRANCH = 3'd1,
        OP_JUMP   = 3'd2,
        OP_CALL   = 3'd3,
        OP_RET    = 3'd4,
        OP_TRAP   = 3'd5,
        OP_TRET   = 3'd6,
        OP_RSVD   = 3'd7
    } op_e;

    logic [WORD_SIZE-1:0] r_addr;
    logic [WORD_SIZE-1:0] r_epc;
    logic [WORD_SIZE-1:0] r_ras [RAS_DEPTH];
    logic [PW-1:0]        r_top;
    logic [CW-1:0]        r_count;
    logic                 r_mis;
    logic                 r_ovf;
    logic                 r_unf;

    op_e                  w_op;
    logic [WORD_SIZE-1:0] w_seq;
    logic [WORD_SIZE-1:0] w_raw;
    logic [WORD_SIZE-1:0] w_next;
    logic                 w_chk;
    logic                 w_mis;
    logic                 w_call;
    logic                 w_ret;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_under;
    logic                 w_save_epc;
    logic                 w_empty;
    logic                 w_full;
    logic [PW-1:0]        w_top_inc;
    logic [PW-1:0]        w_top_dec;

    assign w_op      = op_e'(op);
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL_CNT);
    assign w_top_inc = r_top + PW'(1);
    assign w_top_dec = r_top - PW'(1);

    // Raw target selection per op, then alignment screening into next_addr.
    always_comb begin
        w_seq  = r_addr + INC;
        w_raw  = w_seq;
        w_chk  = 1'b0;
        w_call = 1'b0;
        w_ret  = 1'b0;
        case (w_op)
            OP_BRANCH: begin
                w_raw = r_addr + X;
                w_chk = 1'b1;
            end
            OP_JUMP: begin
                w_raw = X;
                w_chk = 1'b1;
            end
            OP_CALL: begin
                w_raw  = X;
                w_chk  = 1'b1;
                w_call = 1'b1;
            end
            OP_RET: begin
                w_raw = w_empty ? w_seq : r_ras[r_top];
                w_chk = 1'b1;
                w_ret = 1'b1;
            end
            OP_TRAP: begin
                w_raw = TRAP_VECTOR;
            end
            OP_TRET: begin
                w_raw = r_epc;
                w_chk = 1'b1;
            end
            default: begin
                w_raw = w_seq;
            end
        endcase
        w_mis  = w_chk && ((w_raw & ALIGN_MASK) != '0);
        w_next = w_mis ? TRAP_VECTOR : w_raw;
    end

    // Side-effect strobes; a misaligned call is squashed, a return still pops.
    always_comb begin
        w_push     = w_call && !w_mis;
        w_pop      = w_ret && !w_empty;
        w_under    = w_ret && w_empty;
        w_save_epc = (w_op == OP_TRAP) || w_mis;
    end

    // Fetch address register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr <= RESET_VECTOR;
        end else if (en) begin
            r_addr <= w_next;
        end
    end

    // Exception PC captured on trap entry or alignment trap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_epc <= '0;
        end else if (en && w_save_epc) begin
            r_epc <= r_addr;
        end
    end

    // Stack storage has no reset; only entries below the count are read.
    always_ff @(posedge clk) begin
        if (en && w_push) begin
            r_ras[w_top_inc] <= w_seq;
        end
    end

    // Top pointer and occupancy; a push when full overwrites the oldest slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_top   <= '0;
            r_count <= '0;
        end else if (en) begin
            if (w_push) begin
                r_top <= w_top_inc;
                if (!w_full) begin
                    r_count <= r_count + CW'(1);
                end
            end else if (w_pop) begin
                r_top   <= w_top_dec;
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Misalignment pulse follows each enabled edge and holds through stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mis <= 1'b0;
        end else if (en) begin
            r_mis <= w_mis;
        end
    end

    // Sticky stack errors; a new set beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (en && w_push && w_full) begin
                r_ovf <= 1'b1;
            end else if (clr_err) begin
                r_ovf <= 1'b0;
            end
            if (en && w_under) begin
                r_unf <= 1'b1;
            end else if (clr_err) begin
                r_unf <= 1'b0;
            end
        end
    end

    assign addr          = r_addr;
    assign next_addr     = w_next;
    assign epc           = r_epc;
    assign ras_count     = r_count;
    assign misaligned    = r_mis;
    assign ras_overflow  = r_ovf;
    assign ras_underflow = r_unf;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed plan plus random ops checked
// against a queue-based reference model.
module tb_pc_sequencer;

    localparam logic [2:0] SEQ = 3'd0, BRANCH = 3'd1, JUMP = 3'd2;
    localparam logic [2:0] CALL = 3'd3, RET = 3'd4, TRAP = 3'd5, TRET = 3'd6;
    localparam logic [31:0] TVEC = 32'h100;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] X = '0;
    logic        clr_err = 1'b0;
    logic [31:0] addr, next_addr, epc;
    logic [2:0]  ras_count;
    logic        misaligned, ras_overflow, ras_underflow;

    pc_sequencer dut (
        .clk(clk), .rst(rst), .en(en), .op(op), .X(X), .clr_err(clr_err),
        .addr(addr), .next_addr(next_addr), .epc(epc),
        .ras_count(ras_count), .misaligned(misaligned),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] nxt;
        logic [31:0] addr;
        logic [31:0] epc;
        logic [31:0] cnt;
        logic [31:0] mis;
        logic [31:0] ovf;
        logic [31:0] unf;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad = 0;

    // reference model state
    logic [31:0] m_addr, m_epc;
    logic [31:0] m_ras[$];
    bit m_mis, m_ovf, m_unf;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_addr = 32'h0;
        m_epc = 32'h0;
        m_ras.delete();
        m_mis = 0;
        m_ovf = 0;
        m_unf = 0;
    endtask

    task automatic step(bit e, logic [2:0] o, logic [31:0] x, bit c);
        logic [31:0] seq, raw, nxt;
        bit chkd, mis;
        exp_t it;
        @(negedge clk);
        en = e; op = o; X = x; clr_err = c;
        seq = m_addr + 32'd4;
        chkd = 1;
        case (o)
            BRANCH: raw = m_addr + x;
            JUMP, CALL: raw = x;
            RET: raw = (m_ras.size() > 0) ? m_ras[$] : seq;
            TRAP: begin raw = TVEC; chkd = 0; end
            TRET: raw = m_epc;
            default: begin raw = seq; chkd = 0; end
        endcase
        mis = chkd && (raw % 4 != 0);
        nxt = mis ? TVEC : raw;
        it.nxt = nxt;
        if (e) begin
            if (o == TRAP || mis) m_epc = m_addr;
            if (o == CALL && !mis) begin
                if (m_ras.size() == DEPTH) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1;
                end else if (c) m_ovf = 0;
                m_ras.push_back(seq);
            end else if (c) m_ovf = 0;
            if (o == RET) begin
                if (m_ras.size() > 0) begin
                    void'(m_ras.pop_back());
                    if (c) m_unf = 0;
                end else m_unf = 1;
            end else if (c) m_unf = 0;
            m_addr = nxt;
            m_mis = mis;
        end else if (c) begin
            m_ovf = 0;
            m_unf = 0;
        end
        it.addr = m_addr;
        it.epc = m_epc;
        it.cnt = m_ras.size();
        it.mis = 32'(m_mis);
        it.ovf = 32'(m_ovf);
        it.unf = 32'(m_unf);
        sb.push_back(it);
    endtask

    // step, then check addr against a fixed plan value after the edge
    task automatic stepc(bit e, logic [2:0] o, logic [31:0] x, bit c,
                         logic [31:0] exp_addr);
        step(e, o, x, c);
        @(posedge clk);
        #2;
        chk("plan_addr", addr, exp_addr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        en = 1; op = JUMP; X = 32'h40; clr_err = 0;
        rst = 0;
        #1;
        chk("rst_addr", addr, 32'h0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_cnt", 32'(ras_count), 32'h0);
        chk("rst_flags", {29'h0, misaligned, ras_overflow, ras_underflow}, 32'h0);
        en = 0;
        #1;
        rst = 1;
        model_reset();
    endtask

    // monitor: next_addr before the edge, registered state after it
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb[0];
                chk("next_addr", next_addr, e.nxt);
                @(posedge clk);
                #1;
                e = sb.pop_front();
                chk("addr", addr, e.addr);
                chk("epc", epc, e.epc);
                chk("ras_count", 32'(ras_count), e.cnt);
                chk("misaligned", 32'(misaligned), e.mis);
                chk("ras_overflow", 32'(ras_overflow), e.ovf);
                chk("ras_underflow", 32'(ras_underflow), e.unf);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] o;
        logic [31:0] x;
        model_reset();
        do_reset();

        stepc(1, SEQ, 0, 0, 32'h4);
        stepc(1, SEQ, 0, 0, 32'h8);
        stepc(1, SEQ, 0, 0, 32'hC);
        @(posedge clk);
        #3;
        rst = 0;
        #1;
        chk("async_rst_addr", addr, 32'h0);
        en = 0;
        model_reset();
        #1;
        rst = 1;

        stepc(1, JUMP, 32'h10, 0, 32'h10);
        stepc(1, BRANCH, 32'hFFFF_FFF8, 0, 32'h08);
        stepc(1, JUMP, 32'h40, 0, 32'h40);
        stepc(0, JUMP, 32'h80, 0, 32'h40);
        stepc(0, JUMP, 32'h80, 0, 32'h40);
        stepc(1, JUMP, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC);
        stepc(1, SEQ, 0, 0, 32'h0);

        stepc(1, JUMP, 32'h20, 0, 32'h20);
        stepc(1, CALL, 32'h100, 0, 32'h100);
        chk("plan_cnt1", 32'(ras_count), 32'd1);
        stepc(1, RET, 0, 0, 32'h24);
        chk("plan_cnt0", 32'(ras_count), 32'd0);
        stepc(1, RET, 0, 0, 32'h28);
        chk("plan_unf", 32'(ras_underflow), 32'd1);
        stepc(0, SEQ, 0, 1, 32'h28);
        chk("plan_unf_clr", 32'(ras_underflow), 32'd0);

        stepc(1, JUMP, 32'h0, 0, 32'h0);
        stepc(1, CALL, 32'h100, 0, 32'h100);
        stepc(1, CALL, 32'h200, 0, 32'h200);
        stepc(1, CALL, 32'h300, 0, 32'h300);
        stepc(1, CALL, 32'h400, 0, 32'h400);
        chk("plan_ovf_pre", 32'(ras_overflow), 32'd0);
        stepc(1, CALL, 32'h500, 0, 32'h500);
        chk("plan_ovf", 32'(ras_overflow), 32'd1);
        chk("plan_cnt4", 32'(ras_count), 32'd4);
        stepc(1, RET, 0, 0, 32'h404);
        stepc(1, RET, 0, 0, 32'h304);
        stepc(1, RET, 0, 0, 32'h204);
        stepc(1, RET, 0, 0, 32'h104);
        chk("plan_cnt_drain", 32'(ras_count), 32'd0);

        stepc(1, JUMP, 32'h30, 1, 32'h30);
        stepc(1, JUMP, 32'h42, 0, 32'h100);
        chk("plan_mis_epc", epc, 32'h30);
        chk("plan_mis_on", 32'(misaligned), 32'd1);
        stepc(1, TRET, 0, 0, 32'h30);
        chk("plan_mis_off", 32'(misaligned), 32'd0);

        stepc(1, JUMP, 32'h50, 0, 32'h50);
        stepc(1, TRAP, 0, 0, 32'h100);
        chk("plan_trap_epc", epc, 32'h50);
        stepc(1, SEQ, 0, 0, 32'h104);
        stepc(1, TRET, 0, 0, 32'h50);

        for (int i = 0; i < 3000; i++) begin
            if (i % 1000 == 999) do_reset();
            o = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) o = ($urandom_range(0, 1) == 1) ? CALL : RET;
            x = $urandom();
            if (o == BRANCH) x = 32'($signed(12'($urandom())));
            if ($urandom_range(0, 4) != 0) x = x & 32'hFFFF_FFFC;
            step($urandom_range(0, 4) != 0, o, x, $urandom_range(0, 9) == 0);
        end

        @(posedge clk);
        #2;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
